// File: rtl/elevator_call_panel.sv
// ---------------------------------------------------------------------------
// elevator_call_panel
//
// Purpose:
//   Latches raw floor-call buttons into a pending-call vector for a 4-floor
//   elevator controller. Each button is synchronized with two flops, then
//   optionally debounced, then edge-detected. A rising edge sets the floor's
//   pending bit. The bit clears when the door is open at that floor.
//
// Configuration:
//   `define ELEVATOR_DEBOUNCE_EN adds a per-bit debounce filter between the
//   synchronizer and the edge detector. The filter uses DB_CYCLES
//   consecutive disagreeing samples. Without the macro, the filtered level
//   is the synchronized level and no counters are built.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   btn[3:0]    in   raw floor-call buttons (async to clk), bit i = floor i
//   curr_floor  in   floor the car is currently at
//   door_open   in   car door open at curr_floor
//   req[3:0]    out  registered pending-call vector
//   req_count   out  registered popcount of req
//   new_req     out  one-cycle pulse when any req bit was newly set
//   served[3:0] out  one-cycle pulse per floor whose pending call cleared
// ---------------------------------------------------------------------------
module elevator_call_panel #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [1:0] curr_floor,
    input  logic       door_open,
    output logic [3:0] req,
    output logic [2:0] req_count,
    output logic       new_req,
    output logic [3:0] served
);

    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] level;        // synchronized (and optionally filtered) level
    logic [3:0] prev_reg;     // level one cycle earlier, for edge detect
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] req_next;
    logic [2:0] count_next;

    // Two-flop synchronizer on the raw buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef ELEVATOR_DEBOUNCE_EN
    // The filtered level flips only after DB_CYCLES consecutive samples
    // disagree with it. Any sample that agrees restarts the count.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_db
            logic [3:0] cnt_reg;
            logic       filt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg  <= '0;
                    filt_reg <= 1'b0;
                end else if (sync2_reg[gi] != filt_reg) begin
                    if (cnt_reg == 4'(DB_CYCLES - 1)) begin
                        filt_reg <= ~filt_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            assign level[gi] = filt_reg;
        end
    endgenerate
`else
    assign level = sync2_reg;
`endif

    // A floor is cleared when the door is open at that floor.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_clr
            assign clr[gi] = door_open && (curr_floor == 2'(gi));
        end
    endgenerate

    assign rise = level & ~prev_reg;

    // A clear on a bit overrides a set on the same bit in the same cycle.
    assign req_next   = (req | rise) & ~clr;
    assign count_next = 3'(req_next[0]) + 3'(req_next[1])
                      + 3'(req_next[2]) + 3'(req_next[3]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg  <= '0;
            req       <= '0;
            req_count <= '0;
            new_req   <= 1'b0;
            served    <= '0;
        end else begin
            prev_reg  <= level;
            req       <= req_next;
            req_count <= count_next;
            // Only bits that actually go 0 -> 1 count as new calls.
            new_req   <= |(rise & ~req & ~clr);
            served    <= req & clr;
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// ---------------------------------------------------------------------------
// tb_elevator_call_panel
//
// Testbench for elevator_call_panel. The directed scenarios cover reset,
// latch latency, service, a repeat press on a pending floor, simultaneous
// press, clear-versus-set, and reset mid-operation. A randomized phase
// follows. The expected outputs come from a model that works on the
// sampled button history: a call registers when the delayed button level
// rises. With ELEVATOR_DEBOUNCE_EN, the delayed level must also hold for
// DB_CYCLES samples before it counts.
// ---------------------------------------------------------------------------
module tb_elevator_call_panel;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [1:0] curr_floor;
    logic       door_open;
    logic [3:0] req;
    logic [2:0] req_count;
    logic       new_req;
    logic [3:0] served;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state.
    logic [3:0] m_req;
    logic [3:0] m_served;
    logic       m_new;
    logic [3:0] hist[$];      // btn sampled at each post-reset edge
`ifdef ELEVATOR_DEBOUNCE_EN
    logic [3:0] shist[$];     // synchronized level sampled at each edge
    logic [3:0] m_filt, f1, f2;
`endif

    elevator_call_panel #(.DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .btn(btn), .curr_floor(curr_floor),
        .door_open(door_open), .req(req), .req_count(req_count),
        .new_req(new_req), .served(served)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = '0; m_served = '0; m_new = 1'b0;
        hist.delete();
`ifdef ELEVATOR_DEBOUNCE_EN
        shist.delete();
        m_filt = '0; f1 = '0; f2 = '0;
`endif
    endtask

    // Evaluate one rising clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [3:0] lvl2, rise, clr;
        int n;
        n = hist.size();
        // The synchronized level seen at edge k is the btn value sampled at k-2.
        lvl2 = (n >= 2) ? hist[n-2] : 4'b0;
`ifdef ELEVATOR_DEBOUNCE_EN
        rise = f1 & ~f2;
        shist.push_back(lvl2);
        if (shist.size() > DB) void'(shist.pop_front());
        for (int b = 0; b < 4; b++) begin
            bit all_diff;
            all_diff = (shist.size() == DB);
            foreach (shist[j]) if (shist[j][b] == m_filt[b]) all_diff = 1'b0;
            if (all_diff) m_filt[b] = ~m_filt[b];
        end
        f2 = f1;
        f1 = m_filt;
`else
        begin
            logic [3:0] lvl3;
            lvl3 = (n >= 3) ? hist[n-3] : 4'b0;
            rise = lvl2 & ~lvl3;
        end
`endif
        clr      = door_open ? (4'b0001 << curr_floor) : 4'b0000;
        m_new    = |(rise & ~m_req & ~clr);
        m_served = m_req & clr;
        m_req    = (m_req | rise) & ~clr;
        hist.push_back(btn);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic check_all(string tag);
        chk({tag, ".req"},    req,             m_req);
        chk({tag, ".count"},  {1'b0, req_count}, 4'($countones(m_req)));
        chk({tag, ".new"},    {3'b0, new_req}, {3'b0, m_new});
        chk({tag, ".served"}, served,          m_served);
    endtask

    // One clock: model the edge, then check at the following falling edge.
    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_req_immediate", req, 4'b0000);
        chk("rst_cnt_immediate", {1'b0, req_count}, 4'b0000);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; btn = '0; curr_floor = '0; door_open = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset_state");
        reset = 1'b0;
        repeat (3) step("idle");

        // Press floor 2 and hold it; the call latches after the sync delay.
        btn = 4'b0100;
        for (int i = 0; i < 6; i++) step("press2");
        chk("press2_req", req, 4'b0100);
        btn = 4'b0000;
        repeat (3) step("release2");
        chk("release_keeps", req, 4'b0100);

        // Serve floor 2 for one cycle.
        curr_floor = 2'd2; door_open = 1'b1;
        step("serve2");
        chk("serve2_served", served, 4'b0100);
        door_open = 1'b0;
        step("serve2_after");
        chk("serve2_pulse_end", served, 4'b0000);

        // Press floors 0 and 3 together, then press 0 again while pending.
        btn = 4'b1001;
        repeat (6) step("press09");
        btn = 4'b1000;
        repeat (6) step("drop0");
        btn = 4'b1001;
        repeat (6) step("repress0");
        chk("repress_req", req, 4'b1001);
        btn = 4'b0000;
        repeat (3) step("idle2");

        // The door is open at floor 1 while its button rises.
        curr_floor = 2'd1; door_open = 1'b1; btn = 4'b0010;
        repeat (8) step("clear_wins");
        chk("clear_wins_req1", {3'b0, req[1]}, 4'b0000);
        door_open = 1'b0; btn = 4'b0000;
        repeat (3) step("idle3");

        // Clear one floor while a different floor is set.
        curr_floor = 2'd3; door_open = 1'b1; btn = 4'b0100;
        repeat (5) step("clr3_set2");
        door_open = 1'b0; btn = 4'b0000;
        repeat (3) step("idle4");

        // Reset mid-operation with floor 3 held through deassertion.
        btn = 4'b0110;
        repeat (6) step("pre_rst");
        btn = 4'b1000;
        do_reset();
        repeat (6) step("post_rst");
        chk("post_rst_req", req, 4'b1000);
        btn = 4'b0000;
        repeat (3) step("idle5");

`ifdef ELEVATOR_DEBOUNCE_EN
        // A 3-cycle glitch is filtered out; a 6-cycle press is accepted.
        curr_floor = 2'd3; door_open = 1'b1;
        repeat (2) step("db_clr");
        door_open = 1'b0;
        btn = 4'b0100;
        repeat (3) step("glitch");
        btn = 4'b0000;
        repeat (8) step("glitch_after");
        chk("glitch_req2", {3'b0, req[2]}, 4'b0000);
        btn = 4'b0100;
        repeat (6) step("long");
        btn = 4'b0000;
        repeat (6) step("long_after");
        chk("long_req2", {3'b0, req[2]}, 4'b0001);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) btn = 4'($urandom);
            curr_floor = 2'($urandom);
            door_open  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 150) == 0) do_reset();
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
